// File: rtl/sdr_ram_pkg.sv
// Shared types and constants for the RAM stream reader.
// Holds the playback state encoding and output-buffer sizing.
package sdr_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int BUF_DEPTH      = 4;
    localparam int BUF_DEPTH_LOG2 = 2;

    // Count needs one extra bit so that "full" (== BUF_DEPTH) is representable.
    typedef logic [BUF_DEPTH_LOG2:0]   buf_cnt_t;
    typedef logic [BUF_DEPTH_LOG2-1:0] buf_ptr_t;

    localparam buf_cnt_t BUF_FULL = buf_cnt_t'(BUF_DEPTH);
    localparam buf_cnt_t CNT_ONE  = buf_cnt_t'(1);
    localparam buf_ptr_t PTR_ONE  = buf_ptr_t'(1);

endpackage

// File: rtl/ram_stream_buf.sv
// Four-entry output FIFO for the RAM stream reader.
// The head entry is driven straight from storage registers, so o_data is
// registered and holds steady while the consumer stalls.
module ram_stream_buf
    import sdr_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  valid_o,
    output buf_cnt_t              count_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    buf_ptr_t              wr_ptr_q, wr_ptr_d;
    buf_ptr_t              rd_ptr_q, rd_ptr_d;
    buf_cnt_t              count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != BUF_FULL) || do_pop);
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side initiator for a single-port synchronous RAM.
// Issues credit-limited reads (buffered + in-flight words never exceed the
// output FIFO depth) and streams the words on a valid/ready interface,
// either one-shot or looped until stop.
// Optional build macro RAM_STREAM_READER_CHKSUM_EN adds a chksum output:
// the XOR of every word transferred since the last accepted start.
module ram_stream_reader
    import sdr_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DEPTH_LOG2:0]   len,
    input  logic                  loop,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready
`ifdef RAM_STREAM_READER_CHKSUM_EN
   ,output logic [DATA_WIDTH-1:0] chksum
`endif
);

    localparam logic [DEPTH_LOG2:0]   FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = 1;

    rd_state_e             state_q, state_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [DEPTH_LOG2-1:0] last_q, last_d;
    logic                  loop_q, loop_d;
    logic                  inflight_q;
    logic                  len0_done_q, len0_done_d;

    buf_cnt_t              buf_count;
    buf_cnt_t              occupancy;
    logic                  buf_empty;
    logic                  issue;
    logic                  accept_start;
    logic                  drain_done;

    // Read credit: a read may only go out when the FIFO can hold it together
    // with the word already travelling through the RAM output register.
    always_comb begin
        occupancy    = buf_count + buf_cnt_t'(inflight_q);
        issue        = (state_q == RUN) && (occupancy < BUF_FULL);
        buf_empty    = (buf_count == '0);
        accept_start = (state_q == IDLE) && start;
        drain_done   = (state_q == DRAIN) && buf_empty && !inflight_q;
    end

    // Playback FSM next-state and address sequencing.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        loop_d      = loop_q;
        len0_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        len0_done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        addr_d  = '0;
                        loop_d  = loop;
                        // Lengths beyond the RAM depth play the whole RAM.
                        if (len >= FULL_LEN) begin
                            last_d = '1;
                        end else begin
                            last_d = len[DEPTH_LOG2-1:0] - ADDR_ONE;
                        end
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (addr_q == last_q) begin
                        addr_d = '0;
                        if (!loop_q) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                // A read issued in the stop cycle still completes.
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            inflight_q  <= 1'b0;
            len0_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            inflight_q  <= issue;
            len0_done_q <= len0_done_d;
        end
    end

    // The RAM word read last cycle is on ram_do now; capture it into the FIFO.
    ram_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (ram_do),
        .pop_i       (o_ready),
        .head_o      (o_data),
        .valid_o     (o_valid),
        .count_o     (buf_count)
    );

    assign ram_en   = issue;
    assign ram_we   = 1'b0;
    assign ram_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = len0_done_q || drain_done;

`ifdef RAM_STREAM_READER_CHKSUM_EN
    logic [DATA_WIDTH-1:0] chksum_q, chksum_d;

    // Running XOR of transferred words, restarted by each accepted start.
    always_comb begin
        chksum_d = chksum_q;
        if (accept_start) begin
            chksum_d = '0;
        end else if (o_valid && o_ready) begin
            chksum_d = chksum_q ^ o_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum_q <= '0;
        end else begin
            chksum_q <= chksum_d;
        end
    end

    assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader with a behavioural synchronous RAM.
module tb_ram_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, loop;
    logic [4:0] len;
    logic       busy, done, ram_en, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_do;
    logic [7:0] o_data;
    logic       o_valid, o_ready;
`ifdef RAM_STREAM_READER_CHKSUM_EN
    logic [7:0] chksum;
`endif

    ram_stream_reader #(
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .len      (len),
        .loop     (loop),
        .busy     (busy),
        .done     (done),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_do   (ram_do),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
`ifdef RAM_STREAM_READER_CHKSUM_EN
       ,.chksum   (chksum)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle registered read.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_en) ram_do <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int s = 0;
    int rdy_mode = 0;

    int exp_q[$];
    int en_log[$];
    int n_en, n_xfer, n_done, n_busy;
    int first_en_rel, last_en_rel, first_xfer_rel, last_xfer_rel, done_rel, first_busy_rel;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic begin_test();
        exp_q.delete();
        en_log.delete();
        n_en = 0; n_xfer = 0; n_done = 0; n_busy = 0;
        first_en_rel = -1; last_en_rel = -1;
        first_xfer_rel = -1; last_xfer_rel = -1;
        done_rel = -1; first_busy_rel = -1;
    endtask

    task automatic push_seq(input int first, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(first + i);
    endtask

    task automatic start_play(input int l, input logic lp);
        @(posedge clk); #1;
        s = cyc;
        len = 5'(l); loop = lp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && n_done == 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("done_count", n_done, 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    // Ready pattern 1,0,0,1 relative to the start cycle when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1) begin
                case ((cyc - s) % 4)
                    0, 3:    o_ready = 1'b1;
                    default: o_ready = 1'b0;
                endcase
            end
        end
    end

    // Monitor: scoreboard compare, credit check and event timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_en) begin
                check("credit_outstanding_lt4", int'((n_en - n_xfer) < 4), 1);
                check("ram_we_zero", int'(ram_we), 0);
                n_en++;
                en_log.push_back(int'(ram_addr));
                if (first_en_rel < 0) first_en_rel = cyc - s;
                last_en_rel = cyc - s;
            end
            if (o_valid && o_ready) begin
                check("xfer_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("o_data", int'(o_data), exp_q.pop_front());
                n_xfer++;
                if (first_xfer_rel < 0) first_xfer_rel = cyc - s;
                last_xfer_rel = cyc - s;
            end
            if (busy) begin
                n_busy++;
                if (first_busy_rel < 0) first_busy_rel = cyc - s;
            end
            if (done) begin
                n_done++;
                done_rel = cyc - s;
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; len = '0; loop = 1'b0;
        o_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        begin_test();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ram_en", int'(ram_en), 0);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_o_data", int'(o_data), 0);
        rst_n = 1'b1;

        // One-shot, len 5, ready high: exact cycle timing.
        begin_test();
        push_seq(1, 5);
        start_play(5, 1'b0);
        wait_done(40);
        check("t1_first_busy", first_busy_rel, 1);
        check("t1_n_en", n_en, 5);
        check("t1_first_en", first_en_rel, 1);
        check("t1_last_en", last_en_rel, 5);
        for (int i = 0; i < 5; i++) check("t1_en_addr", (i < en_log.size()) ? en_log[i] : -1, i);
        check("t1_first_xfer", first_xfer_rel, 3);
        check("t1_last_xfer", last_xfer_rel, 7);
        check("t1_done_cycle", done_rel, 8);

        // Full RAM with ready 1,0,0,1 backpressure.
        begin_test();
        push_seq(1, 16);
        rdy_mode = 1;
        start_play(16, 1'b0);
        wait_done(200);
        rdy_mode = 0;
        o_ready = 1'b1;
        check("t2_n_xfer", n_xfer, 16);
        check("t2_n_en", n_en, 16);

        // Loop len 3, stop after the 7th transfer.
        begin_test();
        for (int i = 0; i < 10; i++) exp_q.push_back((i % 3) + 1);
        start_play(3, 1'b1);
        for (int k = 0; k < 100 && n_xfer < 7; k++) begin
            @(posedge clk); #1;
        end
        check("t3_stop_point", n_xfer, 7);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done(60);
        check("t3_n_xfer", n_xfer, 10);
        check("t3_n_en", n_en, 10);
        check("t3_done_cycle", done_rel, 13);

        // Zero length: done next cycle, never busy, no reads.
        begin_test();
        start_play(0, 1'b0);
        wait_done(10);
        check("t4_done_cycle", done_rel, 1);
        check("t4_n_busy", n_busy, 0);
        check("t4_n_en", n_en, 0);

        // Oversized length is clamped to the RAM depth.
        begin_test();
        push_seq(1, 16);
        start_play(31, 1'b0);
        wait_done(100);
        check("t5_n_xfer", n_xfer, 16);
        check("t5_n_en", n_en, 16);

        // Reset mid-run with three words buffered.
        begin_test();
        o_ready = 1'b0;
        start_play(16, 1'b0);
        for (int k = 0; k < 20 && (cyc - s) < 5; k++) begin
            @(posedge clk); #1;
        end
        check("t6_pre_n_en", n_en, 4);
        check("t6_pre_valid", int'(o_valid), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(o_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_ram_en", int'(ram_en), 0);
        check("t6_rst_o_data", int'(o_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        o_ready = 1'b1;
        begin_test();
        push_seq(1, 3);
        start_play(3, 1'b0);
        wait_done(40);
        check("t6_replay_addr0", (en_log.size() > 0) ? en_log[0] : -1, 0);
        check("t6_replay_n_xfer", n_xfer, 3);

`ifdef RAM_STREAM_READER_CHKSUM_EN
        begin_test();
        mem[0] = 8'h0F; mem[1] = 8'hF0; mem[2] = 8'h55;
        exp_q.push_back(8'h0F); exp_q.push_back(8'hF0); exp_q.push_back(8'h55);
        start_play(3, 1'b0);
        wait_done(40);
        check("t7_chksum", int'(chksum), 8'hAA);
        for (int i = 0; i < 3; i++) mem[i] = 8'(i + 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for the single-port synchronous RAM in sdr_lib.
  - Drives en/addr on the RAM port and absorbs its 1-cycle registered read latency.
  - Streams the stored words out on a valid/ready interface.
- Used for waveform playback, either one-shot or looped.
- Backpressure never drops or duplicates a word: reads are credit-limited into a small output buffer.

Parameters:
- DATA_WIDTH, 8, word width; must match the RAM.
- DEPTH_LOG2, 4, RAM address width; RAM depth is 2**DEPTH_LOG2.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins playback when idle
- stop  in  1  one-cycle pulse; ends playback gracefully
- len  in  DEPTH_LOG2+1  words per pass; sampled on start
- loop  in  1  1 = wrap and repeat until stop; sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when playback fully drained
- ram_en  out  1  RAM enable; read strobe
- ram_we  out  1  tied 0
- ram_addr  out  DEPTH_LOG2  RAM address
- ram_do  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en
- o_data  out  DATA_WIDTH  stream data
- o_valid  out  1  stream valid
- o_ready  in  1  stream ready; transfer occurs when o_valid && o_ready

Behaviour:
- Reset (rst_n low, async) forces:
  - state IDLE; busy, done, ram_en, ram_we, o_valid = 0
  - ram_addr, o_data = 0; buffer count and in-flight count cleared
  - reset mid-playback aborts immediately; buffered words are discarded
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with len==0 -> done pulse next cycle, stay IDLE, no reads issued.
  - start with len>0 -> RUN; latch L = min(len, 2**DEPTH_LOG2) and loop; addr = 0.
- RUN:
  - Issue a read (ram_en=1, ram_addr=addr) in any cycle where buf_count + inflight < 4.
  - After each issue, addr increments; at addr == L-1 the next addr is 0.
  - At wrap with loop=0 -> DRAIN.
  - At wrap with loop=1 -> keep reading from 0.
- stop in RUN -> DRAIN: no further reads; in-flight and buffered words still emitted.
- stop and a final-address issue in the same cycle: that issue completes, then DRAIN.
- stop in IDLE or DRAIN: ignored. start while busy: ignored.
- DRAIN -> IDLE once inflight==0 and buffer empty; done pulses that cycle and busy drops.
- Read path:
  - A word read in cycle N is captured from ram_do into a 4-entry FIFO at the end of cycle N+1.
  - The FIFO head drives o_data/o_valid registered; o_data is stable while o_valid && !o_ready.
- Latency and throughput:
  - start in cycle 0 -> ram_en in cycle 1 -> first o_valid in cycle 3.
  - Sustained 1 word/cycle with o_ready held high.
- The credit rule guarantees the FIFO never overflows, so no read is issued without space.
- ram_en is 0 in every cycle with no issue. The block never writes the RAM.

Optional Feature:
- Macro: RAM_STREAM_READER_CHKSUM_EN
- Defined:
  - Adds output port chksum [DATA_WIDTH-1:0] = XOR of all words transferred since the last accepted start.
  - Cleared on accepted start and on reset.
  - Updates on every o_valid && o_ready transfer; stable from done onward.
- Undefined: port absent; no checksum logic.

Decomposition:
- Shared package sdr_ram_pkg holds:
  - the state enum (IDLE/RUN/DRAIN)
  - the constant BUF_DEPTH = 4 and its log2
- One natural sub-module: ram_stream_buf, the 4-entry output FIFO with count, push, pop and registered head.

Test Plan:
- RAM preloaded with word i = i+1 (16 words), len=5, loop=0, o_ready=1, start in cycle 0:
  - ram_en high cycles 1-5, addresses 0-4
  - o_data 1,2,3,4,5 on consecutive cycles starting cycle 3
  - done pulse in the cycle after the last transfer
- Same preload, len=16, o_ready toggled 1,0,0,1 repeating -> all 16 words in order, none lost or repeated; ram_en never fires while buffer+inflight = 4.
- Same preload, len=3, loop=1, stop asserted after 7 transfers -> words 1,2,3,1,2,3,1 followed by in-flight extras in order (2,3,…); stream ends cleanly, then a single done pulse.
- len=0 -> done one cycle later, busy stays 0, no ram_en. len=31 -> clamped to 16 words.
- Reset pulse mid-RUN with 3 words buffered -> o_valid, busy, ram_en drop immediately. A new start after release replays from address 0.
- RAM_STREAM_READER_CHKSUM_EN defined, words 0x0F, 0xF0, 0x55 -> chksum = 0xAA after done.
